// File: rtl/up_dn_cntr_pkg.sv
// Shared types and the next-count rule for the up/down counter.
// The rule saturates when UP_DN_CNTR_SAT_EN is defined and wraps modulo 2**width otherwise.
package up_dn_cntr_pkg;

    localparam int CNT_MAX_W = 32;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    // cur is zero-extended to CNT_MAX_W; only the low 'width' bits of the result are meaningful.
    function automatic logic [CNT_MAX_W-1:0] next_count(
        input logic [CNT_MAX_W-1:0] cur,
        input dir_e                 dir,
        input int unsigned          width
    );
        logic [CNT_MAX_W-1:0] max_v;
        logic [CNT_MAX_W-1:0] res;
        max_v = {CNT_MAX_W{1'b1}} >> (CNT_MAX_W - int'(width));
        res   = cur;
        case (dir)
            DIR_UP: begin
                if (cur >= max_v) begin
`ifdef UP_DN_CNTR_SAT_EN
                    res = max_v;
`else
                    res = {CNT_MAX_W{1'b0}};
`endif
                end else begin
                    res = cur + 32'd1;
                end
            end
            DIR_DN: begin
                if (cur == {CNT_MAX_W{1'b0}}) begin
`ifdef UP_DN_CNTR_SAT_EN
                    res = {CNT_MAX_W{1'b0}};
`else
                    res = max_v;
`endif
                end else begin
                    res = cur - 32'd1;
                end
            end
            default: res = cur;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/up_dn_cntr_next.sv
// Combinational next-state logic for the up/down counter (cur, d -> nxt).
// Wrap or saturate behaviour follows UP_DN_CNTR_SAT_EN through the package function.
module up_dn_cntr_next
    import up_dn_cntr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             d,
    output logic [WIDTH-1:0] nxt
);

    logic [CNT_MAX_W-1:0] cur_ext_s;
    logic [CNT_MAX_W-1:0] nxt_ext_s;

    // Widen to the package width, apply the count rule, and narrow back.
    always_comb begin
        cur_ext_s = CNT_MAX_W'(cur);
        nxt_ext_s = next_count(cur_ext_s, dir_e'(d), WIDTH);
        nxt       = nxt_ext_s[WIDTH-1:0];
    end

endmodule

// File: rtl/up_down_counter.sv
// Free-running synchronous up/down counter with synchronous active-high reset.
// Define UP_DN_CNTR_SAT_EN to build a saturating counter instead of a wrapping one.
module up_down_counter
    import up_dn_cntr_pkg::*;
#(
    parameter int                   WIDTH   = 4,
    parameter logic [CNT_MAX_W-1:0] RST_VAL = {CNT_MAX_W{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    output logic [WIDTH-1:0] cnt
);

    if ((WIDTH < 2) || (WIDTH > CNT_MAX_W)) begin : g_bad_width
        $error("up_down_counter: WIDTH must be in 2..32");
    end
    if ((WIDTH < CNT_MAX_W) && ((RST_VAL >> WIDTH) != {CNT_MAX_W{1'b0}})) begin : g_bad_rst_val
        $error("up_down_counter: RST_VAL does not fit in WIDTH bits");
    end

    localparam logic [WIDTH-1:0] RST_VAL_W = RST_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    up_dn_cntr_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .cur (cnt_q),
        .d   (d),
        .nxt (cnt_d)
    );

    // Count register; reset wins over the direction input.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= RST_VAL_W;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: tb/tb_up_down_counter.sv
// Self-checking bench for up_down_counter: a 4-bit/reset-0 instance and an 8-bit/reset-FE instance
// share stimulus and are compared every cycle against an arithmetic reference model.
module tb_up_down_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d   = 1'b0;
    logic [3:0] cnt4;
    logic [7:0] cnt8;

    int  n_checks = 0;
    int  n_errors = 0;
    longint exp4 = 0;
    longint exp8 = 0;

    always #5 clk = ~clk;

    up_down_counter #(.WIDTH(4), .RST_VAL(32'h0)) dut4 (
        .clk (clk), .rst (rst), .d (d), .cnt (cnt4)
    );

    up_down_counter #(.WIDTH(8), .RST_VAL(32'hFE)) dut8 (
        .clk (clk), .rst (rst), .d (d), .cnt (cnt8)
    );

    // Control inputs must be known whenever they are sampled.
    always @(posedge clk) begin
        assert (!$isunknown({rst, d}))
        else $error("rst/d unknown at sampling edge");
    end

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: counter as an integer in [0, 2**w), either modulo or clamped.
    function automatic longint model_next(input longint cur, input bit r, input bit dn,
                                          input int w, input longint rv);
        longint m;
        longint v;
        m = longint'(1) << w;
        if (r) return rv;
        v = dn ? cur - 1 : cur + 1;
`ifdef UP_DN_CNTR_SAT_EN
        if (v < 0)  v = 0;
        if (v >= m) v = m - 1;
`else
        v = (v + m) % m;
`endif
        return v;
    endfunction

    task automatic step(input bit r, input bit dn);
        rst = r;
        d   = dn;
        @(posedge clk);
        exp4 = model_next(exp4, r, dn, 4, 0);
        exp8 = model_next(exp8, r, dn, 8, 254);
        #1;
        check_val("cnt4", longint'(cnt4), exp4);
        check_val("cnt8", longint'(cnt8), exp8);
    endtask

    initial begin
        // 1: reset then count up 0..5
        step(1'b1, 1'b0);
        check_val("rst4_zero", longint'(cnt4), 0);
        check_val("rst8_fe", longint'(cnt8), 254);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b0);
            check_val("up_seq", longint'(cnt4), i);
        end

        // 2: up wrap over 17 edges
        step(1'b1, 1'b0);
        for (int i = 0; i < 17; i++) step(1'b0, 1'b0);
`ifdef UP_DN_CNTR_SAT_EN
        check_val("up_sat", longint'(cnt4), 15);
`else
        check_val("up_wrap", longint'(cnt4), 1);
`endif

        // 3: down from reset
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
`ifdef UP_DN_CNTR_SAT_EN
        check_val("dn_first", longint'(cnt4), 0);
`else
        check_val("dn_first", longint'(cnt4), 15);
`endif
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
`ifdef UP_DN_CNTR_SAT_EN
        check_val("dn_third", longint'(cnt4), 0);
`else
        check_val("dn_third", longint'(cnt4), 13);
`endif

        // 4: reversal after reaching 6
        step(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
        check_val("at_six", longint'(cnt4), 6);
        for (int i = 5; i >= 3; i--) begin
            step(1'b0, 1'b1);
            check_val("reverse", longint'(cnt4), i);
        end

        // 5: reset at 9 with d=0
        step(1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0);
        check_val("at_nine", longint'(cnt4), 9);
        step(1'b1, 1'b0);
        check_val("mid_rst", longint'(cnt4), 0);
        step(1'b0, 1'b0);
        check_val("post_rst", longint'(cnt4), 1);

        // 6: 8-bit instance FE, FF, 00
        step(1'b1, 1'b0);
        check_val("w8_fe", longint'(cnt8), 254);
        step(1'b0, 1'b0);
        check_val("w8_ff", longint'(cnt8), 255);
        step(1'b0, 1'b0);
`ifdef UP_DN_CNTR_SAT_EN
        check_val("w8_sat", longint'(cnt8), 255);
`else
        check_val("w8_wrap", longint'(cnt8), 0);
`endif

        // Random direction runs with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 29) == 0), $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Safety net so the run always ends even if the stimulus stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
